// File: rtl/car_park_gate_ctrl.sv
// Shared entry/exit barrier lane controller: round-robin grant, pass/timeout
// handling, closing hold-off and ownership of the occupancy counter.
module car_park_gate_ctrl #(
  parameter int CNT_W     = 4,
  parameter int CAP       = 15,
  parameter int OPEN_CYC  = 8,
  parameter int CLOSE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             inc,
  output logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout_err
);

  localparam int TMR_W = $clog2((OPEN_CYC > CLOSE_CYC) ? OPEN_CYC : CLOSE_CYC) + 1;
  localparam logic [CNT_W-1:0] CAP_V      = CNT_W'(CAP);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYC - 1);

  typedef enum logic [1:0] {IDLE, OPEN_ENT, OPEN_EXT, CLOSE} state_t;

  state_t           state_q, state_d;
  logic             last_exit_q, last_exit_d;  // 1 when the exit side was served last
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_open_q, gate_open_d;
  logic             entry_grant_q, entry_grant_d;
  logic             exit_grant_q, exit_grant_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic ent_ok, ext_ok, is_ent;

  assign full   = (count_q == CAP_V);
  assign empty  = (count_q == '0);
  assign ent_ok = entry_req && !full;
  assign ext_ok = exit_req && !empty;
  assign is_ent = (state_q == OPEN_ENT);

  always_comb begin
    state_d       = state_q;
    last_exit_d   = last_exit_q;
    timer_d       = timer_q;
    gate_open_d   = 1'b0;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    inc_d         = 1'b0;
    dec_d         = 1'b0;
    timeout_err_d = 1'b0;
    count_d       = count_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Entry wins only when exit is not competing or exit went last.
        if (ent_ok && (!ext_ok || last_exit_q)) begin
          state_d       = OPEN_ENT;
          gate_open_d   = 1'b1;
          entry_grant_d = 1'b1;
        end else if (ext_ok) begin
          state_d      = OPEN_EXT;
          gate_open_d  = 1'b1;
          exit_grant_d = 1'b1;
        end
      end
      OPEN_ENT, OPEN_EXT: begin
        if (car_passed) begin
          inc_d       = is_ent;
          dec_d       = !is_ent;
          count_d     = is_ent ? count_q + 1'b1 : count_q - 1'b1;
          last_exit_d = !is_ent;
          state_d     = CLOSE;
          timer_d     = '0;
        end else if (timer_q == OPEN_LAST) begin
          timeout_err_d = 1'b1;
          last_exit_d   = !is_ent;
          state_d       = CLOSE;
          timer_d       = '0;
        end else begin
          timer_d       = timer_q + 1'b1;
          gate_open_d   = 1'b1;
          entry_grant_d = is_ent;
          exit_grant_d  = !is_ent;
        end
      end
      CLOSE: begin
        if (timer_q == CLOSE_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_exit_q   <= 1'b0;
      timer_q       <= '0;
      gate_open_q   <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      inc_q         <= 1'b0;
      dec_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_exit_q   <= last_exit_d;
      timer_q       <= timer_d;
      gate_open_q   <= gate_open_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      inc_q         <= inc_d;
      dec_q         <= dec_d;
      timeout_err_q <= timeout_err_d;
      count_q       <= count_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign entry_grant = entry_grant_q;
  assign exit_grant  = exit_grant_q;
  assign inc         = inc_q;
  assign dec         = dec_q;
  assign timeout_err = timeout_err_q;
  assign count       = count_q;

endmodule

// File: tb/tb_car_park_gate_ctrl.sv
// Scoreboard bench for car_park_gate_ctrl: stimulus pushes expected gate episodes,
// an independent monitor reconstructs each episode from the outputs and compares.
module tb_car_park_gate_ctrl;
  localparam int CNT_W = 4, CAP = 3, OPEN_CYC = 8, CLOSE_CYC = 2;
  localparam int ENT = 0, EXT = 1;
  localparam int PASS = 0, TMO = 1, ABORT = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic entry_req = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
  logic gate_open, entry_grant, exit_grant, inc, dec, full, empty, timeout_err;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  car_park_gate_ctrl #(
    .CNT_W(CNT_W), .CAP(CAP), .OPEN_CYC(OPEN_CYC), .CLOSE_CYC(CLOSE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .car_passed(car_passed), .gate_open(gate_open), .entry_grant(entry_grant),
    .exit_grant(exit_grant), .inc(inc), .dec(dec), .count(count), .full(full),
    .empty(empty), .timeout_err(timeout_err)
  );

  typedef struct {
    int side;
    int kind;
    int len;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int count_m = 0;
  int last_m = ENT;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endfunction

  // Monitor: rebuild each open episode and compare it with the next expectation.
  initial begin : monitor
    bit in_ep;
    int len, side, kind_act;
    exp_t e;
    in_ep = 0; len = 0; side = ENT;
    forever begin
      @(negedge clk);
      if (inc && dec) check("inc_dec_exclusive", 1, 0);
      if (gate_open) begin
        check("one_grant", int'(entry_grant) + int'(exit_grant), 1);
        if (!in_ep) begin
          in_ep = 1;
          len   = 0;
          side  = exit_grant ? EXT : ENT;
          check("grant_expected", int'(sb.size() > 0), 1);
        end
        len++;
      end else begin
        if (entry_grant || exit_grant) check("grant_without_gate", 1, 0);
        if (in_ep) begin
          in_ep = 0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            kind_act = (inc || dec) ? PASS : (timeout_err ? TMO : ABORT);
            check("side", side, e.side);
            check("kind", kind_act, e.kind);
            if (e.kind != ABORT) begin
              check("open_len", len, e.len);
              check("count", int'(count), e.cnt);
              check("full", int'(full), int'(e.cnt == CAP));
              check("empty", int'(empty), int'(e.cnt == 0));
              if (kind_act == PASS) check("pulse_dir", inc ? ENT : EXT, e.side);
            end
          end
        end else if (inc || dec || timeout_err) begin
          check("stray_pulse", 1, 0);
        end
      end
    end
  end

  // One request episode; w in 1..OPEN_CYC passes on open cycle w, else times out.
  task automatic txn(input bit er, input bit xr, input int w);
    bit e_ok, x_ok;
    exp_t e;
    e_ok = er && (count_m < CAP);
    x_ok = xr && (count_m > 0);
    if (!e_ok && !x_ok) begin
      entry_req = er; exit_req = xr;
      repeat (20) @(negedge clk);
      entry_req = 0; exit_req = 0;
      check("idle_count", int'(count), count_m);
      check("idle_gate", int'(gate_open), 0);
      $display("txn er=%0d xr=%0d: no grant expected, count=%0d", er, xr, count_m);
      return;
    end
    e.side = (e_ok && x_ok) ? ((last_m == ENT) ? EXT : ENT) : (e_ok ? ENT : EXT);
    if (w >= 1 && w <= OPEN_CYC) begin
      e.kind = PASS;
      e.len  = w;
      count_m += (e.side == ENT) ? 1 : -1;
    end else begin
      e.kind = TMO;
      e.len  = OPEN_CYC;
    end
    e.cnt  = count_m;
    last_m = e.side;
    sb.push_back(e);
    entry_req = er; exit_req = xr;
    @(posedge clk);
    @(negedge clk);
    entry_req = 0; exit_req = 0;
    repeat (e.len - 1) @(negedge clk);
    if (e.kind == PASS) car_passed = 1;
    @(negedge clk);
    car_passed = ($urandom_range(0, 3) == 0);  // stray pulse while closing
    @(negedge clk);
    car_passed = 0;
    repeat (3) @(negedge clk);
    $display("txn er=%0d xr=%0d w=%0d: side=%s kind=%0d count=%0d",
             er, xr, w, (e.side == ENT) ? "entry" : "exit", e.kind, count_m);
  endtask

  task automatic reset_mid_open();
    exp_t e;
    e.side = ENT; e.kind = ABORT; e.len = 0; e.cnt = 0;
    sb.push_back(e);
    entry_req = 1;
    @(posedge clk);
    @(negedge clk);
    entry_req = 0;
    @(negedge clk);
    reset = 1; car_passed = 1;
    @(posedge clk);
    #1;
    reset = 0; car_passed = 0;
    @(negedge clk);
    check("rst_gate_open", int'(gate_open), 0);
    check("rst_entry_grant", int'(entry_grant), 0);
    check("rst_inc", int'(inc), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_timeout", int'(timeout_err), 0);
    count_m = 0;
    last_m  = ENT;
    repeat (3) @(negedge clk);
    $display("txn reset mid-open: count=0");
  endtask

  initial begin : stimulus
    bit er, xr;
    repeat (3) @(negedge clk);
    check("reset_gate_open", int'(gate_open), 0);
    check("reset_grants", int'(entry_grant) + int'(exit_grant), 0);
    check("reset_pulses", int'(inc) + int'(dec) + int'(timeout_err), 0);
    check("reset_count", int'(count), 0);
    check("reset_full", int'(full), 0);
    check("reset_empty", int'(empty), 1);
    reset = 0;
    @(negedge clk);

    txn(1, 0, 3);
    txn(1, 0, 1);
    txn(1, 0, 8);            // pass on the expiry cycle beats timeout
    txn(1, 0, 2);            // full: never granted
    check("full_flag", int'(full), 1);
    txn(1, 1, 4);
    txn(1, 1, 5);
    txn(1, 1, 2);
    txn(1, 1, 3);
    txn(0, 1, 0);            // timeout
    txn(0, 1, 1);
    txn(0, 1, 6);
    txn(0, 1, 1);
    txn(0, 1, 2);            // empty: never granted
    check("empty_flag", int'(empty), 1);
    txn(1, 0, 2);
    reset_mid_open();

    repeat (60) begin
      er = 1'($urandom_range(0, 1));
      xr = 1'($urandom_range(0, 1));
      txn(er, xr, int'($urandom_range(0, 10)));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
